// File: rtl/synth_pkg.sv
// Shared widths, constant tables and saturation helpers for the sine voice chain.
// The tables are generated at elaboration from the closed-form note/sine formulas.
package synth_pkg;

   localparam int PHASE_W   = 16;
   localparam int DATA_W    = 16;
   localparam int LUT_AW    = 8;
   localparam int COEF_FRAC = 14;
   localparam int FS_HZ     = 48000;

   localparam int NOTES  = 128;
   localparam int LUT_N  = 1 << LUT_AW;
   localparam int ACC_W  = 20;
   localparam int WIDE_W = 40;

   localparam real PI = 3.14159265358979323846;

   localparam logic signed [15:0] QD = 16'sd16384;

   localparam logic signed [WIDE_W-1:0] ACC_MAX = WIDE_W'(524287);
   localparam logic signed [WIDE_W-1:0] ACC_MIN = WIDE_W'(-524287);
   localparam logic signed [WIDE_W-1:0] S16_MAX = WIDE_W'(32767);
   localparam logic signed [WIDE_W-1:0] S16_MIN = WIDE_W'(-32768);

   typedef logic [NOTES-1:0][15:0] note_rom_t;
   typedef logic [LUT_N-1:0][15:0] qsin_rom_t;

   function automatic real note_hz(input int n);
      return 440.0 * $pow(2.0, (real'(n) - 69.0) / 12.0);
   endfunction

   function automatic note_rom_t build_inc();
      note_rom_t rom;
      for (int n = 0; n < NOTES; n++) begin
         rom[n] = 16'($rtoi(note_hz(n) * 65536.0 / real'(FS_HZ) + 0.5));
      end
      return rom;
   endfunction

   // Cutoff is twice the note pitch, capped at fs/8 so F never exceeds 12540.
   function automatic note_rom_t build_f();
      note_rom_t rom;
      real       fc;
      for (int n = 0; n < NOTES; n++) begin
         fc = 2.0 * note_hz(n);
         if (fc > real'(FS_HZ) / 8.0) fc = real'(FS_HZ) / 8.0;
         rom[n] = 16'($rtoi(16384.0 * 2.0 * $sin(PI * fc / real'(FS_HZ)) + 0.5));
      end
      return rom;
   endfunction

   // Peak clipped to 32766 so the negated lower half never needs 32767+1.
   function automatic qsin_rom_t build_qsin();
      qsin_rom_t rom;
      int        v;
      for (int i = 0; i < LUT_N; i++) begin
         v = $rtoi(32767.0 * $sin(PI / 2.0 * (real'(i) + 0.5) / real'(LUT_N)) + 0.5);
         if (v > 32766) v = 32766;
         rom[i] = 16'(v);
      end
      return rom;
   endfunction

   localparam note_rom_t INC_ROM  = build_inc();
   localparam note_rom_t F_ROM    = build_f();
   localparam qsin_rom_t QSIN_ROM = build_qsin();

   function automatic logic signed [15:0] sat16(input logic signed [WIDE_W-1:0] v);
      if (v > S16_MAX) return 16'sh7FFF;
      if (v < S16_MIN) return 16'sh8000;
      return v[15:0];
   endfunction

   function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [WIDE_W-1:0] v);
      if (v > ACC_MAX) return ACC_MAX[ACC_W-1:0];
      if (v < ACC_MIN) return ACC_MIN[ACC_W-1:0];
      return v[ACC_W-1:0];
   endfunction

endpackage

// File: rtl/phase_acc.sv
// MIDI-note driven phase accumulator, wraps modulo 2^PHASE_W.
module phase_acc
   import synth_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [6:0]         midi,
   output logic [PHASE_W-1:0] phase
);

   always_ff @(posedge clk) begin
      if (rst) begin
         phase <= '0;
      end else begin
         phase <= phase + INC_ROM[midi];
      end
   end

endmodule

// File: rtl/qsine_lut.sv
// Two-stage quarter-wave sine lookup: quadrant/address register, then signed sample.
module qsine_lut
   import synth_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [LUT_AW+1:0]        phase_hi,
   output logic signed [DATA_W-1:0] sine
);

   logic [1:0]               quad;
   logic [LUT_AW-1:0]        addr;
   logic [LUT_AW-1:0]        idx;
   logic signed [DATA_W-1:0] mag;

   assign idx = phase_hi[LUT_AW-1:0];
   assign mag = $signed(QSIN_ROM[addr]);

   // Odd quadrants walk the table backwards; the lower half-cycle is negated.
   always_ff @(posedge clk) begin
      if (rst) begin
         quad <= '0;
         addr <= '0;
         sine <= '0;
      end else begin
         quad <= phase_hi[LUT_AW+1:LUT_AW];
         addr <= phase_hi[LUT_AW] ? ~idx : idx;
         sine <= quad[1] ? -mag : mag;
      end
   end

endmodule

// File: rtl/svf_lp.sv
// Chamberlin state-variable filter, low-pass tap, Q2.14 coefficients, saturating states.
module svf_lp
   import synth_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ena,
   input  logic signed [DATA_W-1:0] x,
   input  logic signed [15:0]       coef_f,
   output logic signed [DATA_W-1:0] y
);

   logic signed [ACC_W-1:0]  low;
   logic signed [ACC_W-1:0]  band;
   logic signed [ACC_W-1:0]  low_n;
   logic signed [ACC_W-1:0]  band_n;
   logic signed [WIDE_W-1:0] f_w;
   logic signed [WIDE_W-1:0] low_w;
   logic signed [WIDE_W-1:0] high_w;
   logic signed [WIDE_W-1:0] band_w;

   // high uses the freshly updated low but the previous band.
   always_comb begin
      f_w    = WIDE_W'(coef_f);
      low_w  = WIDE_W'(low) + ((f_w * WIDE_W'(band)) >>> COEF_FRAC);
      low_n  = sat_acc(low_w);
      high_w = WIDE_W'(x) - WIDE_W'(low_n)
             - ((WIDE_W'(QD) * WIDE_W'(band)) >>> COEF_FRAC);
      band_w = WIDE_W'(band) + ((f_w * high_w) >>> COEF_FRAC);
      band_n = sat_acc(band_w);
   end

   always_ff @(posedge clk) begin
      if (rst || !ena) begin
         low  <= '0;
         band <= '0;
         y    <= '0;
      end else begin
         low  <= low_n;
         band <= band_n;
         y    <= sat16(WIDE_W'(low_n));
      end
   end

endmodule

// File: rtl/sine_voice_core.sv
// Single voice: phase accumulator -> quarter-wave sine -> low-pass SVF.
module sine_voice_core
   import synth_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ena,
   input  logic [6:0]               i_midi,
   output logic [PHASE_W-1:0]       o_phase,
   output logic signed [DATA_W-1:0] o_sine,
   output logic signed [DATA_W-1:0] o_filtered
);

   logic [PHASE_W-1:0] phase;
   logic signed [15:0] coef_f;

   assign o_phase = phase;
   assign coef_f  = $signed(F_ROM[i_midi]);

   phase_acc u_phase (
      .clk   (clk),
      .rst   (rst),
      .midi  (i_midi),
      .phase (phase)
   );

   qsine_lut u_sine (
      .clk      (clk),
      .rst      (rst),
      .phase_hi (phase[PHASE_W-1:PHASE_W-LUT_AW-2]),
      .sine     (o_sine)
   );

   svf_lp u_svf (
      .clk    (clk),
      .rst    (rst),
      .ena    (ena),
      .x      (o_sine),
      .coef_f (coef_f),
      .y      (o_filtered)
   );

endmodule

// File: tb/tb_sine_voice_core.sv
// Directed bench for sine_voice_core with a cycle-level reference model.
module tb_sine_voice_core;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              ena = 1'b0;
   logic [6:0]        i_midi = 7'd69;
   logic [15:0]       o_phase;
   logic signed [15:0] o_sine;
   logic signed [15:0] o_filtered;

   int n_vec = 0;
   int n_err = 0;

   int inc_t [128];
   int f_t   [128];
   int q_t   [256];

   int m_phase = 0, m_quad = 0, m_addr = 0, m_sine = 0;
   int m_low = 0, m_band = 0, m_filt = 0;
   int hist [$];

   sine_voice_core dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .i_midi     (i_midi),
      .o_phase    (o_phase),
      .o_sine     (o_sine),
      .o_filtered (o_filtered)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint clamp(input longint v, input longint lo, input longint hi);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   task automatic build_tables();
      real hz, fc;
      for (int n = 0; n < 128; n++) begin
         hz       = 440.0 * $pow(2.0, real'(n - 69) / 12.0);
         inc_t[n] = int'($floor(hz * 65536.0 / 48000.0 + 0.5));
         fc       = (2.0 * hz < 6000.0) ? 2.0 * hz : 6000.0;
         f_t[n]   = int'($floor(32768.0 * $sin(3.14159265358979 * fc / 48000.0) + 0.5));
      end
      for (int i = 0; i < 256; i++) begin
         q_t[i] = int'($floor(32767.0 * $sin(3.14159265358979 / 2.0 * (real'(i) + 0.5) / 256.0) + 0.5));
         if (q_t[i] > 32766) q_t[i] = 32766;
      end
   endtask

   task automatic model_edge();
      int     np, nq, na, ns;
      longint lo, hi, bd;
      if (rst) begin
         m_phase = 0; m_quad = 0; m_addr = 0; m_sine = 0;
         m_low = 0; m_band = 0; m_filt = 0;
         return;
      end
      np = (m_phase + inc_t[i_midi]) & 32'hFFFF;
      nq = (m_phase >> 14) & 3;
      na = (m_phase >> 6) & 255;
      if (nq & 1) na = 255 - na;
      ns = (m_quad >= 2) ? -q_t[m_addr] : q_t[m_addr];
      if (!ena) begin
         m_low = 0; m_band = 0; m_filt = 0;
      end else begin
         lo = clamp(longint'(m_low) + ((longint'(f_t[i_midi]) * m_band) >>> 14), -524287, 524287);
         hi = longint'(m_sine) - lo - ((longint'(16384) * m_band) >>> 14);
         bd = clamp(longint'(m_band) + ((longint'(f_t[i_midi]) * hi) >>> 14), -524287, 524287);
         m_low  = int'(lo);
         m_band = int'(bd);
         m_filt = int'(clamp(lo, -32768, 32767));
      end
      m_phase = np; m_quad = nq; m_addr = na; m_sine = ns;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("phase", int'(o_phase), m_phase);
      chk("sine", int'(o_sine), m_sine);
      chk("filtered", int'(o_filtered), m_filt);
   endtask

   initial begin
      build_tables();

      // reset held three clocks
      rst = 1'b1; ena = 1'b0; i_midi = 7'd69;
      repeat (3) step();
      chk("rst_phase", int'(o_phase), 0);
      chk("rst_sine", int'(o_sine), 0);
      chk("rst_filt", int'(o_filtered), 0);

      // increments for note 69, then note 0 from the current phase
      rst = 1'b0;
      step(); chk("inc69_1", int'(o_phase), 601);
      step(); chk("inc69_2", int'(o_phase), 1202);
      step(); chk("inc69_3", int'(o_phase), 1803);
      i_midi = 7'd0;
      step(); chk("note0_step", int'(o_phase), 1814);

      // mid-run reset with the filter active
      i_midi = 7'd69; ena = 1'b1;
      repeat (20) step();
      rst = 1'b1;
      step();
      chk("midrst_phase", int'(o_phase), 0);
      chk("midrst_sine", int'(o_sine), 0);
      chk("midrst_filt", int'(o_filtered), 0);

      // wrap with the highest note
      ena = 1'b0; i_midi = 7'd127;
      rst = 1'b0;
      step(); chk("wrap_1", int'(o_phase), 17127);
      step(); chk("wrap_2", int'(o_phase), 34254);
      step(); chk("wrap_3", int'(o_phase), 51381);
      step(); chk("wrap_4", int'(o_phase), 2972);

      // note 69 sine mapping with filter gated off
      rst = 1'b1; i_midi = 7'd69;
      step();
      rst = 1'b0;
      hist.delete();
      hist.push_back(0);
      for (int c = 0; c < 200; c++) begin
         step();
         hist.push_back(m_phase);
         if (hist.size() > 3) begin
            chk("sine_sign", int'(o_sine < 0), (hist[hist.size()-3] >> 15) & 1);
            void'(hist.pop_front());
         end
         chk("gated_zero", int'(o_filtered), 0);
      end

      // filter on note 60
      i_midi = 7'd60; ena = 1'b1;
      repeat (300) step();

      // drop enable: output clears on the next edge, then restart from zero state
      ena = 1'b0;
      step(); chk("ena_drop", int'(o_filtered), 0);
      ena = 1'b1;
      repeat (50) step();

      // highest note, long run at the coefficient cap
      i_midi = 7'd127;
      repeat (10000) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
